// File: rtl/poly1305_block_feeder.sv
// ---------------------------------------------------------------------------
// poly1305_block_feeder
//
// Front end and tag finisher for a Poly1305 per-block multiply/reduce engine.
// Incoming message bytes are packed little-endian into 16-byte blocks and
// padded the Poly1305 way. Each block goes to the external engine with a
// start/done handshake. The running accumulator is kept here. At the end of
// the message it is fully reduced mod p = 2^130-5, and the tag is produced as
// (acc + s) mod 2^128.
//
// Ports
//   clk         single clock, all logic on posedge
//   rst_i       synchronous active-high reset; aborts any message in flight
//   init        1-cycle pulse in IDLE: start a new message, key sampled now
//   msg_empty   sampled with init: 1 = zero-length message
//   key_r       raw r half of the key (clamped here)
//   key_s       s half of the key
//   byte_valid  message byte available
//   byte_data   message byte
//   byte_last   qualifies byte_valid: final byte of the message
//   byte_ready  feeder accepts a byte this cycle (COLLECT only)
//   pb_start    1-cycle start pulse to the block engine
//   pb_m        padded block {pad, 128 data bits}, stable until pb_done
//   pb_r        clamped r
//   pb_a        current accumulator, stable until pb_done
//   pb_a_in     engine result (< 2^130, not necessarily < p)
//   pb_done     engine result valid (only honoured in WAIT)
//   tag         final tag, held until the next tag is produced
//   tag_valid   1-cycle pulse while the new tag is presented
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module poly1305_block_feeder #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic           clk,
    input  logic           rst_i,
    input  logic           init,
    input  logic           msg_empty,
    input  logic [127:0]   key_r,
    input  logic [127:0]   key_s,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    input  logic           byte_last,
    output logic           byte_ready,
    output logic           pb_start,
    output logic [128:0]   pb_m,
    output logic [127:0]   pb_r,
    output logic [129:0]   pb_a,
    input  logic [129:0]   pb_a_in,
    input  logic           pb_done,
    output logic [127:0]   tag,
    output logic           tag_valid,
    output logic           busy
);

    localparam int CntW = $clog2(BLOCK_BYTES);
    localparam logic [CntW-1:0] LastIdx = CntW'(BLOCK_BYTES - 1);
    localparam logic [127:0] RClamp = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [129:0] PrimeP = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT,
        FINAL,
        TAG
    } state_t;

    state_t state_q, state_d;

    logic [127:0]  r_q;
    logic [127:0]  s_q;
    logic [129:0]  acc_q;
    logic [CntW-1:0] cnt_q;
    logic [127:0]  buf_q;
    logic          last_q;
    logic [128:0]  pb_m_q;
    logic [127:0]  tag_q;

    logic          byte_fire;
    logic          block_end;
    logic [127:0]  buf_next;
    logic [CntW:0] fill;
    logic [128:0]  pb_m_next;
    logic [129:0]  acc_red;
    logic [127:0]  tag_sum;

    assign byte_fire = byte_valid & byte_ready;
    assign block_end = byte_fire & ((cnt_q == LastIdx) | byte_last);

    // Buffer contents including the byte being accepted this cycle, so the
    // padded block can be built in the same cycle the final byte lands.
    always_comb begin
        buf_next = buf_q;
        buf_next[{cnt_q, 3'b000} +: 8] = byte_data;
    end

    // The pad bit sits just above the last data byte. With a full block the
    // byte count is 16, which lands the pad on bit 128, so full and partial
    // blocks share one expression; bytes above the count are still zero.
    assign fill      = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
    assign pb_m_next = {1'b0, buf_next} | (129'd1 << {fill, 3'b000});

    // Final full reduction: the engine only guarantees acc < 2^130, and a
    // single conditional subtract of p is enough to land below p.
    assign acc_red = (acc_q >= PrimeP) ? (acc_q - PrimeP) : acc_q;

    // The carry out of the 128-bit add is discarded, giving mod 2^128.
    assign tag_sum = acc_red[127:0] + s_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one block at a time, engine handshake in WAIT, then
    // a reduce cycle and a tag cycle before returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (init) begin
                    state_d = msg_empty ? FINAL : COLLECT;
                end
            end
            COLLECT: begin
                if (block_end) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (pb_done) begin
                    state_d = last_q ? FINAL : COLLECT;
                end
            end
            FINAL: begin
                state_d = TAG;
            end
            TAG: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        byte_ready = 1'b0;
        pb_start   = 1'b0;
        tag_valid  = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            COLLECT: byte_ready = 1'b1;
            ISSUE:   pb_start   = 1'b1;
            TAG:     tag_valid  = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers. The tag is written on the way out of FINAL from the
    // reduced accumulator, so it is already on the tag port during the TAG
    // cycle when tag_valid pulses.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_q    <= '0;
            s_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            buf_q  <= '0;
            last_q <= 1'b0;
            pb_m_q <= '0;
            tag_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init) begin
                        r_q    <= key_r & RClamp;
                        s_q    <= key_s;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        buf_q  <= '0;
                        last_q <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_fire) begin
                        buf_q <= buf_next;
                        cnt_q <= cnt_q + {{(CntW-1){1'b0}}, 1'b1};
                    end
                    if (block_end) begin
                        last_q <= byte_last;
                        pb_m_q <= pb_m_next;
                    end
                end
                WAIT: begin
                    if (pb_done) begin
                        acc_q <= pb_a_in;
                        buf_q <= '0;
                        cnt_q <= '0;
                    end
                end
                FINAL: begin
                    acc_q <= acc_red;
                    tag_q <= tag_sum;
                end
                default: ;
            endcase
        end
    end

    assign pb_m = pb_m_q;
    assign pb_r = r_q;
    assign pb_a = acc_q;
    assign tag  = tag_q;

endmodule

// File: tb/tb_poly1305_block_feeder.sv
// ---------------------------------------------------------------------------
// tb_poly1305_block_feeder
//
// Bench for poly1305_block_feeder. A behavioural block engine answers each
// pb_start with ((a + m) * r) mod p after a programmable delay. Expected
// padded blocks and expected tags are queued when a message is driven and
// are popped when the DUT presents a block or pulses tag_valid.
// ---------------------------------------------------------------------------
module tb_poly1305_block_feeder;

    localparam logic [127:0] RClamp = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [129:0] PrimeP = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
    localparam logic [129:0] ForceA = 130'h3_ffffffff_ffffffff_ffffffff_fffffffe;

    logic           clk;
    logic           rst_i;
    logic           init;
    logic           msg_empty;
    logic [127:0]   key_r;
    logic [127:0]   key_s;
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           byte_last;
    logic           byte_ready;
    logic           pb_start;
    logic [128:0]   pb_m;
    logic [127:0]   pb_r;
    logic [129:0]   pb_a;
    logic [129:0]   pb_a_in;
    logic           pb_done;
    logic [127:0]   tag;
    logic           tag_valid;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   msg_q[$];
    logic [128:0] exp_pbm_q[$];
    logic [127:0] exp_tag_q[$];

    logic [127:0] cur_r;
    logic [129:0] eng_acc;
    int           eng_latency = 2;
    logic         engine_stall = 1'b0;
    logic         engine_force = 1'b0;
    int           start_count = 0;
    int           start_cyc = 0;
    int           done_cyc = 0;
    int           init_cyc = 0;
    int           tag_count = 0;
    int           tag_cyc = 0;
    logic [127:0] last_tag;
    logic [128:0] last_cap_m;

    poly1305_block_feeder #(.BLOCK_BYTES(16)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .init       (init),
        .msg_empty  (msg_empty),
        .key_r      (key_r),
        .key_s      (key_s),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .pb_start   (pb_start),
        .pb_m       (pb_m),
        .pb_r       (pb_r),
        .pb_a       (pb_a),
        .pb_a_in    (pb_a_in),
        .pb_done    (pb_done),
        .tag        (tag),
        .tag_valid  (tag_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: one Poly1305 block step, fully reduced.
    function automatic logic [129:0] poly_step(input logic [129:0] a,
                                               input logic [128:0] m,
                                               input logic [127:0] rc);
        logic [263:0] x;
        x = ({134'd0, a} + {135'd0, m}) * {136'd0, rc};
        x = x % {134'd0, PrimeP};
        return x[129:0];
    endfunction

    // Padded block of n bytes of msg_q starting at index first.
    function automatic logic [128:0] block_of(input int first, input int n);
        logic [128:0] b;
        b = '0;
        for (int j = 0; j < n; j++) b[8*j +: 8] = msg_q[first + j];
        b[8*n] = 1'b1;
        return b;
    endfunction

    function automatic logic [127:0] model_tag(input logic [127:0] kr, input logic [127:0] ks);
        logic [129:0] acc;
        logic [127:0] rc;
        int n;
        acc = '0;
        rc  = kr & RClamp;
        n   = msg_q.size();
        for (int i = 0; i < n; i += 16) begin
            acc = poly_step(acc, block_of(i, (n - i < 16) ? n - i : 16), rc);
        end
        return acc[127:0] + ks;
    endfunction

    // Behavioural block engine with block scoreboard and hold checks.
    initial begin
        logic [128:0] cap_m;
        logic [129:0] cap_a;
        logic [129:0] res;
        logic [128:0] exp_m;
        pb_done = 1'b0;
        pb_a_in = '0;
        forever begin
            @(negedge clk);
            if (pb_start === 1'b1) begin
                start_count++;
                start_cyc  = cyc;
                cap_m      = pb_m;
                cap_a      = pb_a;
                last_cap_m = pb_m;
                checks++;
                if (exp_pbm_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pb_m_unexpected: got %h, no block expected", pb_m);
                end else begin
                    exp_m = exp_pbm_q.pop_front();
                    if (pb_m !== exp_m) begin
                        errors++;
                        $display("[TB] FAIL pb_m: got %h expected %h", pb_m, exp_m);
                    end
                end
                checks++;
                if (pb_r !== cur_r) begin
                    errors++;
                    $display("[TB] FAIL pb_r: got %h expected %h", pb_r, cur_r);
                end
                checks++;
                if (pb_a !== eng_acc) begin
                    errors++;
                    $display("[TB] FAIL pb_a: got %h expected %h", pb_a, eng_acc);
                end
                if (!engine_stall) begin
                    for (int k = 0; k < eng_latency; k++) begin
                        @(negedge clk);
                        checks++;
                        if (pb_m !== cap_m || pb_a !== cap_a || byte_ready !== 1'b0 || pb_start !== 1'b0) begin
                            errors++;
                            $display("[TB] FAIL wait_hold: pb_m %h a %h ready %b start %b, required m %h a %h ready 0 start 0",
                                     pb_m, pb_a, byte_ready, pb_start, cap_m, cap_a);
                        end
                    end
                    res = engine_force ? ForceA : poly_step(cap_a, cap_m, cur_r);
                    pb_a_in  = res;
                    pb_done  = 1'b1;
                    done_cyc = cyc;
                    eng_acc  = res;
                    @(negedge clk);
                    pb_done = 1'b0;
                    pb_a_in = '0;
                end
            end
        end
    end

    // Tag scoreboard.
    initial begin
        logic [127:0] exp_t;
        forever begin
            @(negedge clk);
            if (tag_valid === 1'b1) begin
                tag_count++;
                tag_cyc  = cyc;
                last_tag = tag;
                checks++;
                if (exp_tag_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL tag_unexpected: got tag_valid with %h, none expected", tag);
                end else begin
                    exp_t = exp_tag_q.pop_front();
                    if (tag !== exp_t) begin
                        errors++;
                        $display("[TB] FAIL tag: got %h expected %h", tag, exp_t);
                    end
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic l);
        int budget = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (byte_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_accept: byte_ready %b, required 1 within 100 cycles", byte_ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic run_message(input logic [127:0] kr, input logic [127:0] ks, input logic [127:0] exp_tag);
        int n;
        int base_tags;
        int budget;
        n = msg_q.size();
        for (int i = 0; i < n; i += 16) exp_pbm_q.push_back(block_of(i, (n - i < 16) ? n - i : 16));
        exp_tag_q.push_back(exp_tag);
        cur_r     = kr & RClamp;
        eng_acc   = '0;
        base_tags = tag_count;
        @(negedge clk);
        init      = 1'b1;
        msg_empty = (n == 0);
        key_r     = kr;
        key_s     = ks;
        init_cyc  = cyc;
        @(negedge clk);
        init      = 1'b0;
        msg_empty = 1'b0;
        for (int i = 0; i < n; i++) drive_byte(msg_q[i], i == n - 1);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = '0;
        budget = 0;
        while (tag_count == base_tags && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (tag_count == base_tags) begin
            errors++;
            $display("[TB] FAIL tag_timeout: tag_count %0d, required %0d", tag_count, base_tags + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, byte_ready, pb_start, tag_valid} !== 4'b0 || pb_m !== '0 || pb_a !== '0 || pb_r !== '0 || tag !== '0) begin
            errors++;
            $display("[TB] FAIL %s: busy %b ready %b start %b tag_valid %b m %h a %h r %h tag %h, required all 0",
                     name, busy, byte_ready, pb_start, tag_valid, pb_m, pb_a, pb_r, tag);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_rfc_vector();
        string s = "Cryptographic Forum Research Group";
        logic [127:0] kr = 128'ha806d542_fe52447f_336d5557_78bed685;
        logic [127:0] ks = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301;
        int base = start_count;
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
        run_message(kr, ks, model_tag(kr, ks));
        checks++;
        if (last_tag !== 128'ha927010c_af8b2bc2_c6365130_c11d06a8) begin
            errors++;
            $display("[TB] FAIL rfc_tag: got %h expected a927010caf8b2bc2c6365130c11d06a8", last_tag);
        end
        checks++;
        if (start_count - base != 3) begin
            errors++;
            $display("[TB] FAIL rfc_blocks: got %0d starts, required 3", start_count - base);
        end
    endtask

    task automatic test_single_byte();
        logic [127:0] kr = 128'h01234567_89abcdef_fedcba98_76543210;
        logic [127:0] ks = 128'h55555555_aaaaaaaa_33333333_cccccccc;
        int base = start_count;
        msg_q.delete();
        msg_q.push_back(8'hAB);
        run_message(kr, ks, model_tag(kr, ks));
        checks++;
        if (last_cap_m !== 129'h1AB) begin
            errors++;
            $display("[TB] FAIL single_pb_m: got %h expected 1ab", last_cap_m);
        end
        checks++;
        if (start_count - base != 1) begin
            errors++;
            $display("[TB] FAIL single_blocks: got %0d starts, required 1", start_count - base);
        end
        checks++;
        if (tag_cyc - done_cyc != 2) begin
            errors++;
            $display("[TB] FAIL done_to_tag: got %0d cycles, required 2", tag_cyc - done_cyc);
        end
    endtask

    task automatic test_full_block();
        logic [127:0] kr = 128'hffffffff_ffffffff_ffffffff_ffffffff;
        logic [127:0] ks = 128'h0;
        int base = start_count;
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
        run_message(kr, ks, model_tag(kr, ks));
        checks++;
        if (last_cap_m !== 129'h1_0F0E0D0C_0B0A0908_07060504_03020100) begin
            errors++;
            $display("[TB] FAIL full_pb_m: got %h expected 10f0e0d0c0b0a09080706050403020100", last_cap_m);
        end
        checks++;
        if (start_count - base != 1) begin
            errors++;
            $display("[TB] FAIL full_blocks: got %0d starts, required 1", start_count - base);
        end
        checks++;
        if (start_cyc - init_cyc != 17) begin
            errors++;
            $display("[TB] FAIL init_to_start: got %0d cycles, required 17", start_cyc - init_cyc);
        end
    endtask

    task automatic test_empty_message();
        logic [127:0] ks = 128'hdeadbeef_01020304_cafef00d_a5a5a5a5;
        int base = start_count;
        msg_q.delete();
        run_message(128'h11112222_33334444_55556666_77778888, ks, ks);
        checks++;
        if (start_count != base) begin
            errors++;
            $display("[TB] FAIL empty_blocks: got %0d starts, required 0", start_count - base);
        end
        checks++;
        if (tag_cyc - init_cyc != 2) begin
            errors++;
            $display("[TB] FAIL init_to_tag: got %0d cycles, required 2", tag_cyc - init_cyc);
        end
    endtask

    task automatic test_final_reduce();
        msg_q.delete();
        msg_q.push_back(8'h01);
        engine_force = 1'b1;
        // Engine answers p+3; with s = 2^128-2 the tag wraps to 1.
        run_message(128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 128'hffffffff_ffffffff_ffffffff_fffffffe, 128'd1);
        engine_force = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] kr;
        logic [127:0] ks;
        for (int m = 0; m < 2; m++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            ks = {$urandom, $urandom, $urandom, $urandom};
            msg_q.delete();
            for (int i = 0; i < 33 + 7 * m; i++) msg_q.push_back(8'($urandom));
            run_message(kr, ks, model_tag(kr, ks));
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] kr = 128'h9abcdef0_12345678_0fedcba9_87654321;
        logic [127:0] ks = 128'h13579bdf_2468ace0_fdb97531_eca86420;
        int base = start_count;
        eng_latency = 6;
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'(8'hC0 + i));
        run_message(kr, ks, model_tag(kr, ks));
        eng_latency = 2;
        checks++;
        if (start_count - base != 2) begin
            errors++;
            $display("[TB] FAIL bp_blocks: got %0d starts, required 2", start_count - base);
        end
    endtask

    task automatic test_abort();
        int base_tags = tag_count;
        int base_starts = start_count;
        int budget = 0;
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(8'(3 * i + 1));
        exp_pbm_q.push_back(block_of(0, 16));
        cur_r = 128'h01010101_02020202_03030303_04040404 & RClamp;
        eng_acc = '0;
        engine_stall = 1'b1;
        @(negedge clk);
        init  = 1'b1;
        key_r = 128'h01010101_02020202_03030303_04040404;
        key_s = 128'h77777777_77777777_77777777_77777777;
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < 16; i++) drive_byte(msg_q[i], 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        while (start_count == base_starts && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_wait: ready %b busy %b, required ready 0 busy 1", byte_ready, busy);
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i      = 1'b0;
        byte_valid = 1'b0;
        check_idle_outputs("abort_idle");
        repeat (10) @(negedge clk);
        checks++;
        if (tag_count != base_tags) begin
            errors++;
            $display("[TB] FAIL abort_tag: got %0d tag pulses, required 0", tag_count - base_tags);
        end
        engine_stall = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        init       = 1'b0;
        msg_empty  = 1'b0;
        key_r      = '0;
        key_s      = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_last  = 1'b0;
        cur_r      = '0;
        eng_acc    = '0;
        last_tag   = '0;
        last_cap_m = '0;

        test_reset();
        test_rfc_vector();
        test_single_byte();
        test_full_block();
        test_empty_message();
        test_final_reduce();
        test_back_to_back();
        test_backpressure();
        test_abort();

        repeat (5) @(negedge clk);
        checks++;
        if (exp_pbm_q.size() != 0 || exp_tag_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover: %0d blocks and %0d tags never seen, required 0",
                     exp_pbm_q.size(), exp_tag_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
